// File: rtl/exec_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exec_sequencer_pkg : sequencer state encoding and shared line constants    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package exec_sequencer_pkg;

  localparam int         LINE_WIDTH          = 32;
  localparam logic [7:0] HALT_OPCODE_DEFAULT = 8'hFF;

  typedef enum logic [3:0] {
    SRST   = 4'd0,
    SREAD  = 4'd1,
    SLOAD1 = 4'd2,
    SLOAD2 = 4'd3,
    SLOAD3 = 4'd4,
    SCALC  = 4'd5,
    SWRITE = 4'd6,
    SNXT   = 4'd7,
    SHALT  = 4'd8
  } SequencerState;

  // States that touch RAM and therefore honour ram_busy.
  function automatic logic is_ram_state(input SequencerState s);
    return (s == SLOAD1) || (s == SLOAD2) || (s == SLOAD3) ||
           (s == SCALC)  || (s == SWRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_sequencer_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter : up counter with synchronous clear that sticks at all-ones    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exec_sequencer : per-line instruction-cycle controller with halt, stall    |
// |                  timeout, single-step and saturating perf counters         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int         STALL_LIMIT = 255,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic                  ram_busy,
  input  logic [LINE_WIDTH-1:0] line,
  output SequencerState         q,
  output logic                  halted,
  output logic                  error,
  output logic                  running,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int              STALL_W      = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] c_stall_last = STALL_W'(STALL_LIMIT - 1);

  SequencerState      r_state;
  SequencerState      w_next_state;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_error;
  logic               w_stall;
  logic               w_timeout;
  logic               w_restart;
  logic               w_retire;
  logic               w_running;
  logic               w_line_unused;

  // Only the opcode byte steers the sequencer.
  assign w_line_unused = ^line[LINE_WIDTH-9:0];

  // The edge that would bring the stall count to STALL_LIMIT halts instead.
  assign w_stall   = is_ram_state(r_state) && ram_busy;
  assign w_timeout = w_stall && (r_stall_cnt == c_stall_last);
  assign w_restart = (r_state == SHALT) && start;
  assign w_retire  = (r_state == SWRITE) && !ram_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= SRST;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SRST:   if (start) w_next_state = SREAD;
      SREAD:  w_next_state = (line[LINE_WIDTH-1 -: 8] == HALT_OPCODE) ? SHALT : SLOAD1;
      SLOAD1: if (w_timeout) w_next_state = SHALT; else if (!ram_busy) w_next_state = SLOAD2;
      SLOAD2: if (w_timeout) w_next_state = SHALT; else if (!ram_busy) w_next_state = SLOAD3;
      SLOAD3: if (w_timeout) w_next_state = SHALT; else if (!ram_busy) w_next_state = SCALC;
      SCALC:  if (w_timeout) w_next_state = SHALT; else if (!ram_busy) w_next_state = SWRITE;
      SWRITE: if (w_timeout) w_next_state = SHALT; else if (!ram_busy) w_next_state = SNXT;
      SNXT:   if (!step_mode || step) w_next_state = SREAD;
      SHALT:  if (start) w_next_state = SRST;
      default: w_next_state = SRST;
    endcase
  end

  always_comb begin
    q         = r_state;
    halted    = (r_state == SHALT);
    w_running = (r_state != SRST) && (r_state != SHALT);
    running   = w_running;
    error     = r_error;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_timeout) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end else begin
      r_stall_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end else if (w_restart) begin
      r_error <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (w_restart),
    .inc   (w_retire),
    .count (instr_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (w_restart),
    .inc   (w_running),
    .count (cycle_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exec_sequencer : directed vectors for exec_sequencer (4-bit counters,   |
// |                     stall limit 4)                                         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  start = 1'b0;
  logic                  step_mode = 1'b0;
  logic                  step = 1'b0;
  logic                  ram_busy = 1'b0;
  logic [LINE_WIDTH-1:0] line = 32'h0100_0000;
  SequencerState         q;
  logic                  halted;
  logic                  error;
  logic                  running;
  logic [3:0]            instr_count;
  logic [3:0]            cycle_count;

  int n_checks = 0;
  int n_pass   = 0;

  exec_sequencer #(.HALT_OPCODE(8'hFF), .STALL_LIMIT(4), .CNT_WIDTH(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .ram_busy    (ram_busy),
    .line        (line),
    .q           (q),
    .halted      (halted),
    .error       (error),
    .running     (running),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          step_mode;
    logic          step;
    logic          busy;
    logic [7:0]    op;
    SequencerState exp_q;
    int            exp_instr;
    int            exp_cycle;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic sm, input logic st, input logic b,
                              input logic [7:0] op, input SequencerState eq,
                              input int ei, input int ec);
    vec_t v;
    v.start = s; v.step_mode = sm; v.step = st; v.busy = b; v.op = op;
    v.exp_q = eq; v.exp_instr = ei; v.exp_cycle = ec;
    return v;
  endfunction

  initial begin
    // Expected state/counts after the edge on which each row's inputs are sampled.
    vecs[0]  = mk(1, 0, 0, 0, 8'h01, SREAD,  0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 8'h01, SLOAD1, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 8'h01, SLOAD2, 0, 2);
    vecs[3]  = mk(0, 0, 0, 1, 8'h01, SLOAD2, 0, 3);
    vecs[4]  = mk(0, 0, 0, 1, 8'h01, SLOAD2, 0, 4);
    vecs[5]  = mk(0, 0, 0, 1, 8'h01, SLOAD2, 0, 5);
    vecs[6]  = mk(0, 0, 0, 0, 8'h01, SLOAD3, 0, 6);
    vecs[7]  = mk(0, 0, 0, 0, 8'h01, SCALC,  0, 7);
    vecs[8]  = mk(0, 0, 0, 0, 8'h01, SWRITE, 0, 8);
    vecs[9]  = mk(0, 0, 0, 0, 8'h01, SNXT,   1, 9);
    vecs[10] = mk(0, 0, 1, 1, 8'h01, SREAD,  1, 10);
    vecs[11] = mk(0, 0, 0, 1, 8'h01, SLOAD1, 1, 11);
    vecs[12] = mk(0, 0, 1, 0, 8'h01, SLOAD2, 1, 12);
    vecs[13] = mk(1, 0, 0, 0, 8'h01, SLOAD3, 1, 13);
    vecs[14] = mk(0, 0, 0, 0, 8'h01, SCALC,  1, 14);
    vecs[15] = mk(0, 0, 0, 0, 8'h01, SWRITE, 1, 15);
    vecs[16] = mk(0, 0, 0, 0, 8'h01, SNXT,   2, 15);
    vecs[17] = mk(0, 1, 0, 0, 8'h01, SNXT,   2, 15);

    #3;
    check("reset_q",       int'(q), int'(SRST));
    check("reset_running", int'(running), 0);
    check("reset_halted",  int'(halted), 0);
    check("reset_error",   int'(error), 0);
    check("reset_instr",   int'(instr_count), 0);
    check("reset_cycle",   int'(cycle_count), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("srst_hold", int'(q), int'(SRST));

    for (int i = 0; i < 18; i++) begin
      start     = vecs[i].start;
      step_mode = vecs[i].step_mode;
      step      = vecs[i].step;
      ram_busy  = vecs[i].busy;
      line      = {vecs[i].op, 24'h00_1234};
      tick();
      check($sformatf("vec%0d_q", i),     int'(q),           int'(vecs[i].exp_q));
      check($sformatf("vec%0d_instr", i), int'(instr_count), vecs[i].exp_instr);
      check($sformatf("vec%0d_cycle", i), int'(cycle_count), vecs[i].exp_cycle);
      check($sformatf("vec%0d_error", i), int'(error),       0);
    end

    // Single-step pause: SNXT is held while step_mode=1 and step stays low.
    for (int k = 0; k < 19; k++) begin
      tick();
      check("step_hold_q", int'(q), int'(SNXT));
    end
    step = 1'b1;
    tick();
    check("step_release_q", int'(q), int'(SREAD));
    step = 1'b0;

    // Halt opcode in SREAD beats a simultaneous start.
    line  = 32'hFF00_0000;
    start = 1'b1;
    tick();
    check("halt_q",       int'(q), int'(SHALT));
    check("halt_halted",  int'(halted), 1);
    check("halt_running", int'(running), 0);
    check("halt_instr",   int'(instr_count), 2);
    start = 1'b0;
    line  = 32'h0100_0000;
    tick();
    check("halt_hold_q", int'(q), int'(SHALT));
    start = 1'b1;
    tick();
    check("restart_q",     int'(q), int'(SRST));
    check("restart_instr", int'(instr_count), 0);
    check("restart_cycle", int'(cycle_count), 0);
    step_mode = 1'b0;

    // Stall timeout in SCALC.
    tick();
    check("to_sread", int'(q), int'(SREAD));
    start = 1'b0;
    repeat (4) tick();
    check("to_scalc", int'(q), int'(SCALC));
    ram_busy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("to_stall_q",   int'(q), int'(SCALC));
      check("to_stall_err", int'(error), 0);
    end
    tick();
    check("to_halt_q",      int'(q), int'(SHALT));
    check("to_halt_error",  int'(error), 1);
    check("to_halt_halted", int'(halted), 1);
    ram_busy = 1'b0;
    tick();
    check("to_err_sticky", int'(error), 1);
    start = 1'b1;
    tick();
    check("to_restart_q",     int'(q), int'(SRST));
    check("to_restart_error", int'(error), 0);
    check("to_restart_instr", int'(instr_count), 0);
    check("to_restart_cycle", int'(cycle_count), 0);

    // instr_count saturation over 16 back-to-back instructions.
    tick();
    start = 1'b0;
    check("sat_sread", int'(q), int'(SREAD));
    for (int k = 1; k <= 16; k++) begin
      repeat (7) tick();
      check("sat_q",     int'(q), int'(SREAD));
      check("sat_instr", int'(instr_count), (k > 15) ? 15 : k);
    end
    check("sat_cycle", int'(cycle_count), 15);

    // Asynchronous reset in the middle of SWRITE.
    repeat (5) tick();
    check("mid_swrite", int'(q), int'(SWRITE));
    #2;
    rstn = 1'b0;
    #1;
    check("areset_q",     int'(q), int'(SRST));
    check("areset_instr", int'(instr_count), 0);
    check("areset_cycle", int'(cycle_count), 0);
    check("areset_run",   int'(running), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("post_reset_q", int'(q), int'(SRST));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
